// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment read-back path: segment codes, FSM states, default settle depth.
// Hex digits 8..F are only decoded when SEG7_READER_HEX_EN is defined.
package seg7_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  // Bits 6:0 = segments g..a, bit 0 = a
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern lookup: magnitude, blank flag and illegal flag.
// SEG7_READER_HEX_EN adds the hex glyphs 8..F as legal magnitudes.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] mag,
  output logic       blank,
  output logic       err
);

  always_comb begin
    mag   = 4'd0;
    blank = 1'b0;
    err   = 1'b0;
    case (pattern)
      SEG_BLANK: blank = 1'b1;
      SEG_0:     mag = 4'd0;
      SEG_1:     mag = 4'd1;
      SEG_2:     mag = 4'd2;
      SEG_3:     mag = 4'd3;
      SEG_4:     mag = 4'd4;
      SEG_5:     mag = 4'd5;
      SEG_6:     mag = 4'd6;
      SEG_7:     mag = 4'd7;
`ifdef SEG7_READER_HEX_EN
      SEG_8:     mag = 4'd8;
      SEG_9:     mag = 4'd9;
      SEG_A:     mag = 4'd10;
      SEG_B:     mag = 4'd11;
      SEG_C:     mag = 4'd12;
      SEG_D:     mag = 4'd13;
      SEG_E:     mag = 4'd14;
      SEG_F:     mag = 4'd15;
`endif
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Debounces a read-back seven-segment bus and emits each newly settled pattern once over valid/ready.
// Define SEG7_READER_HEX_EN to accept hex digits 8..F (otherwise they count as illegal).
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [7:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sign,
  output logic [3:0] out_mag,
  output logic [4:0] out_value,
  output logic       out_blank,
  output logic       out_err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] sample_p0;
  logic [7:0] cand_p1;
  logic [7:0] last_p1;
  logic [3:0] dec_mag;
  logic       dec_blank;
  logic       dec_err;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic signed [4:0] signed_value(input logic sign, input logic [3:0] mag);
    logic signed [4:0] m;
    m = signed'({1'b0, mag});
    return sign ? -m : m;
  endfunction

  seg7_pattern_decode u_decode (
    .pattern (cand_p1[6:0]),
    .mag     (dec_mag),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sample_p0 <= '0;
      cand_p1   <= '0;
      last_p1   <= '0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      out_value <= '0;
      out_blank <= 1'b0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // Stage p0: input sample register; the FSM below only sees sample_p0
      sample_p0 <= seg_in;
      // Stage p1: candidate settle / emit handshake
      case (state)
        IDLE: begin
          if (sample_p0 != last_p1) begin
            cand_p1 <= sample_p0;
            cnt     <= 4'd1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == STABLE_N) begin
            out_valid <= 1'b1;
            out_sign  <= cand_p1[7];
            out_mag   <= dec_mag;
            out_value <= signed_value(cand_p1[7], dec_mag);
            out_blank <= dec_blank;
            out_err   <= dec_err;
            state     <= EMIT;
          end else if (sample_p0 == cand_p1) begin
            cnt <= cnt + 4'd1;
          end else if (sample_p0 == last_p1) begin
            // Bouncing back to what was already reported must not re-arm an emission
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cand_p1 <= sample_p0;
            cnt     <= 4'd1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            last_p1   <= cand_p1;
            out_valid <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
            if (out_err) err_cnt <= sat_inc(err_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_seg7_reader;

  localparam int S = 4;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [3:0] out_mag;
  logic [4:0] out_value;
  logic       out_blank;
  logic       out_err;
  logic [7:0] err_cnt;

  always #5 clk_2 = ~clk_2;

  seg7_reader #(.STABLE_CYCLES(S)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_value (out_value),
    .out_blank (out_blank),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: glyph table index = magnitude
  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG7_READER_HEX_EN
  int n_legal = 16;
`else
  int n_legal = 8;
`endif

  logic [7:0] m_sample, m_last, m_pat;
  logic [7:0] hist [$];
  logic       m_valid, m_sign, m_blank, m_err;
  logic [3:0] m_mag;
  logic [4:0] m_value;
  int         m_errcnt;

  task automatic model_decode(input logic [7:0] p);
    int v;
    m_sign  = p[7];
    m_mag   = 4'd0;
    m_blank = (p[6:0] == 7'h00);
    m_err   = !m_blank;
    for (int i = 0; i < n_legal; i++)
      if (p[6:0] == codes[i]) begin
        m_mag = i[3:0];
        m_err = 1'b0;
      end
    v = m_sign ? -int'(m_mag) : int'(m_mag);
    m_value = v[4:0];
  endtask

  // One clock edge: a pattern is emitted once the last S samples seen while listening agree and differ from the last report
  task automatic model_step();
    if (reset) begin
      m_sample = 8'h00; m_last = 8'h00; m_pat = 8'h00;
      m_valid = 0; m_sign = 0; m_blank = 0; m_err = 0; m_mag = 0; m_value = 0; m_errcnt = 0;
      hist.delete();
      return;
    end
    if (m_valid) begin
      if (out_ready) begin
        m_last = m_pat;
        if (m_err && m_errcnt < 255) m_errcnt++;
        m_valid = 1'b0;
        hist.delete();
      end
    end else begin
      bit all_same = (hist.size() == S);
      for (int i = 0; i < hist.size(); i++) if (hist[i] != hist[0]) all_same = 0;
      if (all_same && hist[0] != m_last) begin
        m_pat = hist[0];
        model_decode(m_pat);
        m_valid = 1'b1;
        hist.delete();
      end else begin
        hist.push_back(m_sample);
        if (hist.size() > S) void'(hist.pop_front());
      end
    end
    m_sample = seg_in;
  endtask

  task automatic tick();
    @(posedge clk_2);
    model_step();
    @(negedge clk_2);
    check("valid", out_valid, m_valid);
    check("err_cnt", err_cnt, m_errcnt);
    if (m_valid) begin
      check("sign", out_sign, m_sign);
      check("mag", out_mag, m_mag);
      check("value", out_value, m_value);
      check("blank", out_blank, m_blank);
      check("err", out_err, m_err);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int c = 0;
    while (!out_valid && c < budget) begin
      tick();
      c++;
    end
    check(tag, out_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nv, got_mag, r, hold;
    reset = 1'b1; seg_in = 8'h00; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_sign", out_sign, 0);
    check("rst_mag", out_mag, 0);
    check("rst_value", out_value, 0);
    check("rst_blank", out_blank, 0);
    check("rst_err", out_err, 0);
    check("rst_errcnt", err_cnt, 0);
    reset = 1'b0;
    tick(); tick();
    check("idle_no_emit", out_valid, 0);

    // Digit 3 with consumer always ready
    seg_in = 8'h4F; out_ready = 1'b1; lat = 0; nv = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (out_valid) begin
        if (lat == 0) begin
          lat = c;
          check("d3_mag", out_mag, 3);
          check("d3_value", out_value, 3);
        end
        nv++;
      end
    end
    check("d3_latency", lat, S + 2);
    check("d3_pulses", nv, 1);

    // Negative 4 with backpressure
    seg_in = 8'hE6; out_ready = 1'b0;
    wait_valid(20, "neg4_wait");
    check("neg4_sign", out_sign, 1);
    check("neg4_mag", out_mag, 4);
    check("neg4_value", out_value, 32'h1C);
    nv = 0;
    repeat (5) begin tick(); if (out_valid) nv++; end
    check("neg4_hold", nv, 5);
    out_ready = 1'b1;
    tick();
    check("neg4_drop", out_valid, 0);
    nv = 0;
    repeat (10) begin tick(); if (out_valid) nv++; end
    check("neg4_single", nv, 0);

    // Toggling bus never settles
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      seg_in = (i % 2 == 1) ? 8'h5B : 8'h06;
      tick();
      if (out_valid) nv++;
    end
    check("toggle_quiet", nv, 0);
    seg_in = 8'h5B;
    wait_valid(20, "toggle_settle");
    check("toggle_mag", out_mag, 2);
    tick();

    // 0x7F: hex 8 or illegal depending on build
    seg_in = 8'h7F;
    wait_valid(20, "g8_wait");
`ifdef SEG7_READER_HEX_EN
    check("g8_mag", out_mag, 8);
    check("g8_err", out_err, 0);
    tick();
    check("g8_errcnt", err_cnt, 0);
`else
    check("g8_err", out_err, 1);
    check("g8_mag", out_mag, 0);
    tick();
    check("g8_errcnt", err_cnt, 1);
`endif

    // Reset during SETTLE discards the pending digit 5
    seg_in = 8'h6D; nv = 0; got_mag = -1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_settle_valid", out_valid, 0);
    reset = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid) begin nv++; got_mag = out_mag; end
    end
    check("rst_settle_once", nv, 1);
    check("rst_settle_mag", got_mag, 5);

    // Reset during EMIT drops out_valid
    seg_in = 8'h66; out_ready = 1'b0;
    wait_valid(20, "rst_emit_wait");
    reset = 1'b1;
    tick();
    check("rst_emit_valid", out_valid, 0);
    reset = 1'b0; out_ready = 1'b1;
    repeat (10) tick();

    // Error counter saturation
    for (int k = 0; k < 300; k++) begin
      seg_in = (k % 2 == 1) ? 8'h02 : 8'h01;
      repeat (6) tick();
    end
    repeat (3) tick();
    check("errcnt_sat", err_cnt, 255);

    // Randomized traffic
    reset = 1'b1; tick(); reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       seg_in = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
      else if (r == 7) seg_in = {1'($urandom_range(0, 1)), 7'h00};
      else             seg_in = 8'($urandom);
      hold = $urandom_range(1, 9);
      repeat (hold) begin
        out_ready = ($urandom_range(0, 9) < 7);
        reset = ($urandom_range(0, 199) == 0);
        tick();
      end
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
